// File: rtl/trigger_detector.sv
// Threshold-crossing trigger with hysteresis, holdoff and optional auto-rearm.
// The sample stream is forwarded with one clock of latency so that trigger lines up with the crossing sample.
module trigger_detector #(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8,
  parameter int unsigned HOLDOFF_WIDTH     = 16,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                         arm,
  input  logic                         disarm,
  input  logic [1:0]                   mode,
  input  logic                         auto_rearm,
  input  logic [SAMPLE_DATA_WIDTH-1:0] threshold,
  input  logic [SAMPLE_DATA_WIDTH-1:0] hysteresis,
  input  logic [HOLDOFF_WIDTH-1:0]     holdoff,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         trigger,
  output logic                         armed,
  output logic [COUNT_WIDTH-1:0]       trigger_count
);

  localparam logic [HOLDOFF_WIDTH-1:0] HoldOne = {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0]   CntOne  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StSeekPre, StSeekRise, StSeekFall, StHoldoff} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   mode_q;
  logic                         auto_rearm_q;
  logic [SAMPLE_DATA_WIDTH-1:0] threshold_q, hysteresis_q;
  logic [HOLDOFF_WIDTH-1:0]     holdoff_q;
  logic [HOLDOFF_WIDTH-1:0]     hold_cnt_q, hold_cnt_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic                         axiov_q, trigger_q;
  logic [SAMPLE_DATA_WIDTH-1:0] axiod_q;

  logic                         arm_go, fire, rise_ok, fall_ok;
  logic [SAMPLE_DATA_WIDTH:0]   low_ext, high_ext;
  logic [SAMPLE_DATA_WIDTH-1:0] low_lvl, high_lvl;
  state_e                       rearm_state;

  // arm is only honoured in IDLE, and disarm overrides it.
  assign arm_go      = (state_q == StIdle) && arm && !disarm;
  assign rise_ok     = (mode_q != 2'b01);
  assign fall_ok     = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign rearm_state = auto_rearm_q ? StSeekPre : StIdle;

  // Saturating hysteresis band around the latched threshold.
  always_comb begin
    low_ext  = {1'b0, threshold_q} - {1'b0, hysteresis_q};
    high_ext = {1'b0, threshold_q} + {1'b0, hysteresis_q};
    low_lvl  = low_ext[SAMPLE_DATA_WIDTH]  ? '0 : low_ext[SAMPLE_DATA_WIDTH-1:0];
    high_lvl = high_ext[SAMPLE_DATA_WIDTH] ? '1 : high_ext[SAMPLE_DATA_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    fire       = 1'b0;
    if (disarm) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm) state_d = StSeekPre;
        end
        StSeekPre: begin
          if (axiiv) begin
            if (rise_ok && (axiid < low_lvl)) begin
              state_d = StSeekRise;
            end else if (fall_ok && (axiid > high_lvl)) begin
              state_d = StSeekFall;
            end
          end
        end
        StSeekRise: fire = axiiv && (axiid >= threshold_q);
        StSeekFall: fire = axiiv && (axiid <= threshold_q);
        StHoldoff: begin
          if (hold_cnt_q == '0) state_d = rearm_state;
          else                  hold_cnt_d = hold_cnt_q - HoldOne;
        end
        default: state_d = StIdle;
      endcase
      if (fire) begin
        if (holdoff_q != '0) begin
          state_d    = StHoldoff;
          hold_cnt_d = holdoff_q - HoldOne;
        end else begin
          state_d = rearm_state;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (arm_go) begin
      count_d = '0;
    end else if (fire && (count_q != '1)) begin
      count_d = count_q + CntOne;
    end
  end

  // Datapath: config latch, sample forwarding, trigger pulse, counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= '0;
      auto_rearm_q <= 1'b0;
      threshold_q  <= '0;
      hysteresis_q <= '0;
      holdoff_q    <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      trigger_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      if (arm_go) begin
        mode_q       <= mode;
        auto_rearm_q <= auto_rearm;
        threshold_q  <= threshold;
        hysteresis_q <= hysteresis;
        holdoff_q    <= holdoff;
      end
      axiov_q   <= axiiv;
      axiod_q   <= axiid;
      trigger_q <= fire;
      count_q   <= count_d;
    end
  end

  // Outputs.
  always_comb begin
    axiov         = axiov_q;
    axiod         = axiod_q;
    trigger       = trigger_q;
    trigger_count = count_q;
    armed         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_trigger_detector.sv
// Directed bench for trigger_detector; expected values are worked out by hand from the crossing rules.
// A narrow trigger_count lets saturation be reached within a short run.
module tb_trigger_detector;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axiiv = 1'b0;
  logic [7:0]    axiid = '0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic [1:0]    mode = '0;
  logic          auto_rearm = 1'b0;
  logic [7:0]    threshold = '0;
  logic [7:0]    hysteresis = '0;
  logic [15:0]   holdoff = '0;
  logic          axiov;
  logic [7:0]    axiod;
  logic          trigger;
  logic          armed;
  logic [CW-1:0] trigger_count;

  int n_vec = 0;
  int n_err = 0;

  trigger_detector #(
    .SAMPLE_DATA_WIDTH(8),
    .HOLDOFF_WIDTH    (16),
    .COUNT_WIDTH      (CW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .axiiv        (axiiv),
    .axiid        (axiid),
    .arm          (arm),
    .disarm       (disarm),
    .mode         (mode),
    .auto_rearm   (auto_rearm),
    .threshold    (threshold),
    .hysteresis   (hysteresis),
    .holdoff      (holdoff),
    .axiov        (axiov),
    .axiod        (axiod),
    .trigger      (trigger),
    .armed        (armed),
    .trigger_count(trigger_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one sample; outputs are observed 1 time unit after the capturing edge.
  task automatic step(input logic v, input logic [7:0] d);
    axiiv = v;
    axiid = d;
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [1:0] m, input logic ar, input logic [7:0] thr,
                         input logic [7:0] hys, input logic [15:0] ho);
    mode       = m;
    auto_rearm = ar;
    threshold  = thr;
    hysteresis = hys;
    holdoff    = ho;
    arm        = 1'b1;
    step(1'b0, 8'd0);
    arm        = 1'b0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    step(1'b0, 8'd0);
    disarm = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic trig, input logic [7:0] d,
                            input logic [CW-1:0] cnt);
    check({tag, ".trigger"}, trigger, trig);
    check({tag, ".axiod"}, axiod, d);
    check({tag, ".count"}, trigger_count, cnt);
  endtask

  initial begin
    logic [7:0]    d;
    logic          exp_trig;
    logic [CW-1:0] exp_cnt;
    int            fires;

    // Reset values, including the forwarding path.
    axiiv = 1'b1;
    axiid = 8'd55;
    repeat (2) @(posedge clk);
    #1;
    check("rst.axiov", axiov, 1'b0);
    check("rst.axiod", axiod, 8'd0);
    check("rst.trigger", trigger, 1'b0);
    check("rst.armed", armed, 1'b0);
    check("rst.count", trigger_count, 0);
    rst = 1'b0;
    step(1'b0, 8'd0);
    check("idle.armed", armed, 1'b0);

    // Rising single shot; config inputs change after arm and must be ignored.
    arm_cfg(2'b00, 1'b0, 8'd100, 8'd10, 16'd0);
    threshold  = 8'd0;
    hysteresis = 8'd0;
    check("rise.armed", armed, 1'b1);
    step(1'b1, 8'd95);
    check("rise.axiov", axiov, 1'b1);
    expect_out("rise.95a", 1'b0, 8'd95, 0);
    step(1'b1, 8'd89);
    expect_out("rise.89", 1'b0, 8'd89, 0);
    step(1'b1, 8'd95);
    expect_out("rise.95b", 1'b0, 8'd95, 0);
    step(1'b1, 8'd100);
    expect_out("rise.100", 1'b1, 8'd100, 1);
    check("rise.armed_drop", armed, 1'b0);
    step(1'b1, 8'd120);
    expect_out("rise.120", 1'b0, 8'd120, 1);

    // Hysteresis reject; arm also clears the count.
    arm_cfg(2'b00, 1'b0, 8'd100, 8'd10, 16'd0);
    check("hyst.count_clr", trigger_count, 0);
    step(1'b1, 8'd95);
    check("hyst.t0", trigger, 1'b0);
    step(1'b1, 8'd105);
    check("hyst.t1", trigger, 1'b0);
    step(1'b1, 8'd95);
    check("hyst.t2", trigger, 1'b0);
    step(1'b1, 8'd105);
    check("hyst.t3", trigger, 1'b0);
    check("hyst.armed", armed, 1'b1);
    do_disarm();
    check("hyst.disarm", armed, 1'b0);

    // Falling, auto-rearm, holdoff 4: fires at i=1,7,13 (6-cycle spacing).
    arm_cfg(2'b01, 1'b1, 8'd50, 8'd5, 16'd4);
    exp_cnt = '0;
    for (int i = 0; i < 14; i++) begin
      d = (i % 2 == 0) ? 8'd60 : 8'd40;
      step(1'b1, d);
      exp_trig = (i == 1) || (i == 7) || (i == 13);
      if (exp_trig) exp_cnt++;
      expect_out($sformatf("fall.%0d", i), exp_trig, d, exp_cnt);
      check($sformatf("fall.armed%0d", i), armed, 1'b1);
    end
    // Disarm while in holdoff, then no further triggers.
    disarm = 1'b1;
    step(1'b1, 8'd60);
    disarm = 1'b0;
    check("dis.armed", armed, 1'b0);
    check("dis.trigger", trigger, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? 8'd60 : 8'd40;
      step(1'b1, d);
      expect_out($sformatf("dis.%0d", i), 1'b0, d, 3);
    end
    check("dis.armed_end", armed, 1'b0);

    // Either mode, holdoff 0 with auto-rearm.
    arm_cfg(2'b10, 1'b1, 8'd128, 8'd8, 16'd0);
    step(1'b1, 8'd200);
    expect_out("either.200", 1'b0, 8'd200, 0);
    step(1'b1, 8'd100);
    expect_out("either.100a", 1'b1, 8'd100, 1);
    step(1'b1, 8'd100);
    expect_out("either.100b", 1'b0, 8'd100, 1);
    step(1'b1, 8'd150);
    expect_out("either.150", 1'b1, 8'd150, 2);
    do_disarm();

    // Valid gaps in seek-pre and inside the crossing.
    arm_cfg(2'b00, 1'b0, 8'd100, 8'd10, 16'd0);
    step(1'b0, 8'd50);
    check("gap.axiov0", axiov, 1'b0);
    step(1'b1, 8'd80);
    step(1'b0, 8'd200);
    expect_out("gap.inv200", 1'b0, 8'd200, 0);
    step(1'b0, 8'd150);
    check("gap.inv150", trigger, 1'b0);
    step(1'b1, 8'd99);
    check("gap.99", trigger, 1'b0);
    step(1'b0, 8'd120);
    check("gap.inv120", trigger, 1'b0);
    step(1'b1, 8'd101);
    expect_out("gap.101", 1'b1, 8'd101, 1);

    // Threshold 0 with hysteresis 255 can never arm the rising seek.
    arm_cfg(2'b00, 1'b1, 8'd0, 8'd255, 16'd0);
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? 8'd0 : 8'd255;
      step(1'b1, d);
      check($sformatf("sat0.%0d", i), trigger, 1'b0);
    end
    do_disarm();

    // Count saturation: either mode alternating 200/100 fires on every 100.
    arm_cfg(2'b10, 1'b1, 8'd128, 8'd8, 16'd0);
    fires = 0;
    for (int i = 0; i < 520; i++) begin
      d = (i % 2 == 0) ? 8'd200 : 8'd100;
      step(1'b1, d);
      exp_trig = (i % 2 == 1);
      if (exp_trig) fires++;
      exp_cnt = (fires > 255) ? 8'hFF : fires[CW-1:0];
      if (i == 9 || i >= 505) expect_out($sformatf("satc.%0d", i), exp_trig, d, exp_cnt);
    end
    check("satc.final", trigger_count, 8'hFF);
    do_disarm();
    check("satc.retain", trigger_count, 8'hFF);
    arm    = 1'b1;
    disarm = 1'b1;
    step(1'b0, 8'd0);
    arm    = 1'b0;
    disarm = 1'b0;
    check("armdis.armed", armed, 1'b0);

    // Reset on the crossing sample suppresses the pulse.
    arm_cfg(2'b00, 1'b0, 8'd100, 8'd10, 16'd0);
    step(1'b1, 8'd80);
    check("rstx.armed", armed, 1'b1);
    rst = 1'b1;
    step(1'b1, 8'd120);
    rst = 1'b0;
    check("rstx.trigger", trigger, 1'b0);
    check("rstx.axiov", axiov, 1'b0);
    check("rstx.axiod", axiod, 8'd0);
    check("rstx.armed", armed, 1'b0);
    check("rstx.count", trigger_count, 0);
    step(1'b1, 8'd120);
    check("rstx.after", trigger, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
